// File: rtl/rect_fill_ctrl_if.sv
// rect_fill_ctrl_if: pixel write port between the rectangle filler and the
// layer RAM arbiter.
//   wr_req   - a pixel write is pending (master -> slave)
//   wr_grant - the arbiter accepts the pending write on this edge (slave -> master)
//   wr_addr  - framebuffer address, y*H_RES + x
//   wr_data  - 3-bit RGB pixel colour
//   wr_layer - target layer 0..2
interface rect_fill_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              wr_req;
  logic              wr_grant;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic [1:0]        wr_layer;

  modport master (output wr_req, wr_addr, wr_data, wr_layer, input wr_grant);
  modport slave  (input wr_req, wr_addr, wr_data, wr_layer, output wr_grant);
endinterface

// File: rtl/rect_fill_ctrl.sv
// rect_fill_ctrl: rectangle draw sequencer for the paint/VGA path.
// Captures two corners from the cursor, drives the live preview corners and
// state, then fills the rectangle one pixel per accepted write in raster order.
// Ports:
//   clk, reset_n             - clock, async active-low reset
//   btn_mark, btn_cancel     - one-cycle button pulses
//   cursor_x, cursor_y       - cursor position (clamped on capture)
//   draw_color, layer_sel    - fill colour and target layer (3 maps to 0)
//   state_rect               - 10 IDLE, 01 ANCHOR, 11 FILL
//   recg_{x,y}_pt{1,2}       - preview corners
//   wr                       - pixel write port (master side)
//   busy, done               - fill in progress / one-cycle completion pulse
module rect_fill_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_mark,
  input  logic        btn_cancel,
  input  logic [9:0]  cursor_x,
  input  logic [9:0]  cursor_y,
  input  logic [2:0]  draw_color,
  input  logic [1:0]  layer_sel,
  output logic [1:0]  state_rect,
  output logic [9:0]  recg_x_pt1,
  output logic [9:0]  recg_y_pt1,
  output logic [9:0]  recg_x_pt2,
  output logic [9:0]  recg_y_pt2,
  rect_fill_ctrl_if.master wr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b10,
    S_ANCHOR = 2'b01,
    S_FILL   = 2'b11
  } state_t;

  localparam logic [9:0]        X_LIM  = 10'(H_RES - 1);
  localparam logic [9:0]        Y_LIM  = 10'(V_RES - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

  state_t            state;
  logic [9:0]        xmin, xmax, ymax, fx, fy;
  logic [ADDR_W-1:0] row_base, addr_q;
  logic [2:0]        data_q;
  logic [1:0]        layer_q;

  // clamped cursor and the bounding box formed with the new second corner
  logic [9:0]        cx, cy, nxmin, nxmax, nymin, nymax;
  logic [ADDR_W-1:0] row0;

  always_comb begin
    cx    = (cursor_x > X_LIM) ? X_LIM : cursor_x;
    cy    = (cursor_y > Y_LIM) ? Y_LIM : cursor_y;
    nxmin = (recg_x_pt1 < cx) ? recg_x_pt1 : cx;
    nxmax = (recg_x_pt1 < cx) ? cx : recg_x_pt1;
    nymin = (recg_y_pt1 < cy) ? recg_y_pt1 : cy;
    nymax = (recg_y_pt1 < cy) ? cy : recg_y_pt1;
    row0  = ADDR_W'(nymin) * STRIDE;
  end

  // request/busy decode straight from the state register, so they are glitch-free
  assign state_rect  = state;
  assign busy        = (state == S_FILL);
  assign wr.wr_req   = (state == S_FILL);
  assign wr.wr_addr  = addr_q;
  assign wr.wr_data  = data_q;
  assign wr.wr_layer = layer_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      recg_x_pt1 <= '0;
      recg_y_pt1 <= '0;
      recg_x_pt2 <= '0;
      recg_y_pt2 <= '0;
      xmin       <= '0;
      xmax       <= '0;
      ymax       <= '0;
      fx         <= '0;
      fy         <= '0;
      row_base   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      layer_q    <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (btn_mark) begin
            recg_x_pt1 <= cx;
            recg_y_pt1 <= cy;
            recg_x_pt2 <= cx;
            recg_y_pt2 <= cy;
            state      <= S_ANCHOR;
          end
        end
        S_ANCHOR: begin
          // cancel beats mark and leaves the corners as they were
          if (btn_cancel) begin
            state <= S_IDLE;
          end else begin
            recg_x_pt2 <= cx;
            recg_y_pt2 <= cy;
            if (btn_mark) begin
              xmin     <= nxmin;
              xmax     <= nxmax;
              ymax     <= nymax;
              fx       <= nxmin;
              fy       <= nymin;
              row_base <= row0;
              addr_q   <= row0 + ADDR_W'(nxmin);
              data_q   <= draw_color;
              layer_q  <= (layer_sel == 2'd3) ? 2'd0 : layer_sel;
              state    <= S_FILL;
            end
          end
        end
        S_FILL: begin
          // address register advances only on accept, so it is stable while stalled
          if (wr.wr_grant) begin
            if (fx < xmax) begin
              fx     <= fx + 10'd1;
              addr_q <= addr_q + ADDR_W'(1);
            end else if (fy < ymax) begin
              fx       <= xmin;
              fy       <= fy + 10'd1;
              row_base <= row_base + STRIDE;
              addr_q   <= row_base + STRIDE + ADDR_W'(xmin);
            end else begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Directed testbench for rect_fill_ctrl.
module tb_rect_fill_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       btn_mark = 1'b0, btn_cancel = 1'b0;
  logic [9:0] cursor_x = '0, cursor_y = '0;
  logic [2:0] draw_color = '0;
  logic [1:0] layer_sel = '0;
  logic [1:0] state_rect;
  logic [9:0] recg_x_pt1, recg_y_pt1, recg_x_pt2, recg_y_pt2;
  logic       busy, done;

  rect_fill_ctrl_if #(.ADDR_W(19)) wr_bus ();

  rect_fill_ctrl #(.H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
    .clk(clk), .reset_n(reset_n), .btn_mark(btn_mark), .btn_cancel(btn_cancel),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .draw_color(draw_color),
    .layer_sel(layer_sel), .state_rect(state_rect),
    .recg_x_pt1(recg_x_pt1), .recg_y_pt1(recg_y_pt1),
    .recg_x_pt2(recg_x_pt2), .recg_y_pt2(recg_y_pt2),
    .wr(wr_bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int wq[$], dq[$], cq[$];
  int done_cyc, stable_err;
  bit gpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // stimulus helper: one-cycle mark pulse at a cursor position
  task automatic mark(input int x, input int y);
    cursor_x = 10'(x);
    cursor_y = 10'(y);
    btn_mark = 1'b1;
    @(negedge clk);
    btn_mark = 1'b0;
  endtask

  // records accepted writes until done (or the cycle budget runs out)
  task automatic run_fill(input int budget, input bit stall);
    bit held = 1'b0;
    int held_addr = 0;
    wq.delete(); dq.delete(); cq.delete();
    done_cyc = -1;
    stable_err = 0;
    for (int c = 0; c < budget; c++) begin
      wr_bus.wr_grant = stall ? gpat[c % 4] : 1'b1;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (held && int'(wr_bus.wr_addr) != held_addr) stable_err++;
      if (wr_bus.wr_req === 1'b1 && wr_bus.wr_grant) begin
        wq.push_back(int'(wr_bus.wr_addr));
        dq.push_back(int'(wr_bus.wr_data));
        cq.push_back(c);
      end
      held = (wr_bus.wr_req === 1'b1) && !wr_bus.wr_grant;
      held_addr = int'(wr_bus.wr_addr);
      @(negedge clk);
    end
    wr_bus.wr_grant = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (state_rect !== 2'b10) begin n_fail++; $display("FAIL reset_state: got %b expected 10", state_rect); end
    n_chk++; if (wr_bus.wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags: req=%b busy=%b done=%b expected 0", wr_bus.wr_req, busy, done); end
    n_chk++; if (recg_x_pt1 !== 0 || recg_y_pt2 !== 0 || wr_bus.wr_addr !== 0 || wr_bus.wr_data !== 0 || wr_bus.wr_layer !== 0) begin n_fail++; $display("FAIL reset_regs: pt1x=%0d pt2y=%0d addr=%0d expected 0", recg_x_pt1, recg_y_pt2, wr_bus.wr_addr); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_fill();
    int exp_a[6] = '{12810, 12811, 12812, 13450, 13451, 13452};
    draw_color = 3'b101;
    layer_sel = 2'd2;
    wr_bus.wr_grant = 1'b1;
    mark(10, 20);
    n_chk++; if (state_rect !== 2'b01) begin n_fail++; $display("FAIL basic_anchor_state: got %b expected 01", state_rect); end
    n_chk++; if (recg_x_pt1 !== 10'd10 || recg_y_pt1 !== 10'd20) begin n_fail++; $display("FAIL basic_pt1: got (%0d,%0d) expected (10,20)", recg_x_pt1, recg_y_pt1); end
    n_chk++; if (wr_bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL basic_anchor_req: got %b expected 0", wr_bus.wr_req); end
    mark(12, 21);
    n_chk++; if (state_rect !== 2'b11 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_fill_state: got %b busy=%b expected 11 busy=1", state_rect, busy); end
    n_chk++; if (wr_bus.wr_layer !== 2'd2) begin n_fail++; $display("FAIL basic_layer: got %0d expected 2", wr_bus.wr_layer); end
    run_fill(30, 1'b0);
    n_chk++; if (wq.size() != 6) begin n_fail++; $display("FAIL basic_count: got %0d expected 6", wq.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) begin
        n_chk++; if (wq[i] != exp_a[i]) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, wq[i], exp_a[i]); end
        n_chk++; if (dq[i] != 5) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected 5", i, dq[i]); end
        n_chk++; if (cq[i] != i) begin n_fail++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, cq[i], i); end
      end
    end
    n_chk++; if (done_cyc != 6) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 6", done_cyc); end
    n_chk++; if (state_rect !== 2'b10 || busy !== 1'b0 || wr_bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL basic_end_state: got %b busy=%b req=%b expected 10 0 0", state_rect, busy, wr_bus.wr_req); end
    n_chk++; if (recg_x_pt2 !== 10'd12 || recg_y_pt2 !== 10'd21) begin n_fail++; $display("FAIL basic_pt2: got (%0d,%0d) expected (12,21)", recg_x_pt2, recg_y_pt2); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_reversed();
    int exp_a[6] = '{12810, 12811, 12812, 13450, 13451, 13452};
    mark(12, 21);
    mark(10, 20);
    run_fill(30, 1'b0);
    n_chk++; if (wq.size() != 6) begin n_fail++; $display("FAIL rev_count: got %0d expected 6", wq.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) begin
        n_chk++; if (wq[i] != exp_a[i]) begin n_fail++; $display("FAIL rev_addr[%0d]: got %0d expected %0d", i, wq[i], exp_a[i]); end
      end
    end
    n_chk++; if (done_cyc != 6) begin n_fail++; $display("FAIL rev_done_cycle: got %0d expected 6", done_cyc); end
    @(negedge clk);
  endtask

  task automatic test_stalls();
    int exp_a[4] = '{0, 1, 640, 641};
    int exp_c[4] = '{0, 3, 4, 7};
    mark(0, 0);
    mark(1, 1);
    run_fill(40, 1'b1);
    n_chk++; if (wq.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", wq.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        n_chk++; if (wq[i] != exp_a[i]) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d expected %0d", i, wq[i], exp_a[i]); end
        n_chk++; if (cq[i] != exp_c[i]) begin n_fail++; $display("FAIL stall_cycle[%0d]: got %0d expected %0d", i, cq[i], exp_c[i]); end
      end
    end
    n_chk++; if (stable_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", stable_err); end
    n_chk++; if (done_cyc != 8) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 8", done_cyc); end
    @(negedge clk);
  endtask

  task automatic test_rubber_cancel();
    int req_seen = 0;
    mark(5, 5);
    cursor_x = 10'd100;
    cursor_y = 10'd50;
    @(negedge clk);
    n_chk++; if (recg_x_pt2 !== 10'd100 || recg_y_pt2 !== 10'd50) begin n_fail++; $display("FAIL rubber_pt2: got (%0d,%0d) expected (100,50)", recg_x_pt2, recg_y_pt2); end
    n_chk++; if (recg_x_pt1 !== 10'd5 || recg_y_pt1 !== 10'd5) begin n_fail++; $display("FAIL rubber_pt1: got (%0d,%0d) expected (5,5)", recg_x_pt1, recg_y_pt1); end
    btn_cancel = 1'b1;
    @(negedge clk);
    btn_cancel = 1'b0;
    n_chk++; if (state_rect !== 2'b10) begin n_fail++; $display("FAIL cancel_state: got %b expected 10", state_rect); end
    for (int i = 0; i < 4; i++) begin
      if (wr_bus.wr_req !== 1'b0) req_seen++;
      @(negedge clk);
    end
    n_chk++; if (req_seen != 0) begin n_fail++; $display("FAIL cancel_no_write: got %0d request cycles expected 0", req_seen); end
    // cancel in IDLE is a no-op
    btn_cancel = 1'b1;
    @(negedge clk);
    btn_cancel = 1'b0;
    n_chk++; if (state_rect !== 2'b10) begin n_fail++; $display("FAIL idle_cancel: got %b expected 10", state_rect); end
    mark(30, 30);
    cursor_x = 10'd40;
    btn_mark = 1'b1;
    btn_cancel = 1'b1;
    @(negedge clk);
    btn_mark = 1'b0;
    btn_cancel = 1'b0;
    n_chk++; if (state_rect !== 2'b10 || wr_bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL mark_cancel: got %b req=%b expected 10 req=0", state_rect, wr_bus.wr_req); end
    n_chk++; if (recg_x_pt2 !== 10'd30) begin n_fail++; $display("FAIL mark_cancel_hold: got %0d expected 30", recg_x_pt2); end
  endtask

  task automatic test_clamp();
    layer_sel = 2'd3;
    mark(700, 500);
    n_chk++; if (recg_x_pt1 !== 10'd639 || recg_y_pt1 !== 10'd479) begin n_fail++; $display("FAIL clamp_pt1: got (%0d,%0d) expected (639,479)", recg_x_pt1, recg_y_pt1); end
    mark(700, 500);
    n_chk++; if (wr_bus.wr_layer !== 2'd0) begin n_fail++; $display("FAIL clamp_layer: got %0d expected 0", wr_bus.wr_layer); end
    run_fill(10, 1'b0);
    n_chk++; if (wq.size() != 1) begin n_fail++; $display("FAIL clamp_count: got %0d expected 1", wq.size()); end
    if (wq.size() > 0) begin
      n_chk++; if (wq[0] != 307199) begin n_fail++; $display("FAIL clamp_addr: got %0d expected 307199", wq[0]); end
    end
    n_chk++; if (done_cyc != 1) begin n_fail++; $display("FAIL clamp_done_cycle: got %0d expected 1", done_cyc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    layer_sel = 2'd1;
    wr_bus.wr_grant = 1'b1;
    mark(0, 0);
    mark(3, 3);
    repeat (3) @(negedge clk);
    n_chk++; if (wr_bus.wr_addr !== 19'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL midreset_progress: addr=%0d busy=%b expected 3 1", wr_bus.wr_addr, busy); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (wr_bus.wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: req=%b busy=%b done=%b expected 0", wr_bus.wr_req, busy, done); end
    n_chk++; if (state_rect !== 2'b10) begin n_fail++; $display("FAIL midreset_state: got %b expected 10", state_rect); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mark(7, 8);
    n_chk++; if (state_rect !== 2'b01 || wr_bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL postreset_anchor: got %b req=%b expected 01 0", state_rect, wr_bus.wr_req); end
    n_chk++; if (recg_x_pt1 !== 10'd7 || recg_y_pt1 !== 10'd8) begin n_fail++; $display("FAIL postreset_pt1: got (%0d,%0d) expected (7,8)", recg_x_pt1, recg_y_pt1); end
    btn_cancel = 1'b1;
    @(negedge clk);
    btn_cancel = 1'b0;
  endtask

  initial begin
    wr_bus.wr_grant = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_fill();
    test_reversed();
    test_stalls();
    test_rubber_cancel();
    test_clamp();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rect_fill_ctrl.md
Name: rect_fill_ctrl

Overview:
- Sequences rectangle drawing for the paint/VGA path.
- Captures two corners from the cursor on button presses and drives the live rectangle-preview coordinates and state to the colour-selection logic.
- On the second corner, fills the rectangle into the selected layer framebuffer, one pixel per write, through a req/grant port shared with the display reader.

Parameters:
- H_RES, 640, visible width in pixels; row stride of the framebuffer.
- V_RES, 480, visible height in pixels.
- ADDR_W, 19, framebuffer address width; address = y*H_RES + x.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_mark  in  1  one-cycle pulse (already debounced); captures a corner.
- btn_cancel  in  1  one-cycle pulse; abandons the corner capture.
- cursor_x  in  10  cursor column.
- cursor_y  in  10  cursor row.
- draw_color  in  3  RGB colour used for the fill.
- layer_sel  in  2  target layer: 0, 1 or 2; 3 is treated as 0.
- state_rect  out  2  preview state: 2'b10 IDLE (preview hidden), 2'b01 ANCHOR, 2'b11 FILL.
- recg_x_pt1, recg_y_pt1  out  10 each  first corner.
- recg_x_pt2, recg_y_pt2  out  10 each  second corner.
- wr_req  out  1  write request to the layer RAM arbiter.
- wr_grant  in  1  the write is accepted at the rising edge where wr_req and wr_grant are both 1.
- wr_addr  out  ADDR_W  pixel address.
- wr_data  out  3  pixel colour.
- wr_layer  out  2  layer being written.
- busy  out  1  high while the block is in FILL.
- done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (asynchronous, active-low):
  - state goes to IDLE, so state_rect = 2'b10.
  - All corner outputs, wr_addr, wr_data and wr_layer are 0.
  - wr_req, busy and done are 0.
  - Reset mid-fill abandons the fill immediately; pixels already written are not restored.
- Corner capture clamps cursor_x to H_RES-1 and cursor_y to V_RES-1.
- IDLE:
  - btn_mark: pt1 and pt2 both take the clamped cursor; next state is ANCHOR.
  - btn_cancel is ignored.
- ANCHOR:
  - Every cycle, pt2 takes the clamped cursor (rubber band); pt1 holds.
  - btn_cancel: next state is IDLE; corners hold their values.
  - btn_mark: pt2 takes the cursor, then the block latches:
    - xmin/xmax = min/max(pt1x, new pt2x)
    - ymin/ymax = min/max(pt1y, new pt2y)
    - layer = layer_sel and colour = draw_color, both frozen for the whole fill.
  - After latching, next state is FILL.
  - If btn_mark and btn_cancel arrive in the same cycle, cancel wins.
- FILL:
  - busy = 1. Pixel counters fx starts at xmin and fy at ymin.
  - row_base starts at ymin*H_RES; compute it once on entry, multiply or shift-add allowed.
  - wr_req = 1 and wr_addr = row_base + fx.
  - wr_addr, wr_data and wr_layer stay stable until accepted.
  - On accept:
    - fx < xmax: fx increments.
    - otherwise, fx returns to xmin, fy increments, and row_base increases by H_RES.
  - After acceptance there is no gap: the next beat is presented in the following cycle, so throughput is 1 pixel/clk while wr_grant is held high.
  - wr_grant low stalls the block with no state change.
  - Accept of pixel (xmax, ymax):
    - next state is IDLE.
    - wr_req and busy are 0 in the next cycle.
    - done = 1 for exactly that one cycle.
  - btn_mark and btn_cancel are ignored during FILL; a request is never withdrawn before it is granted.
  - Total writes = (xmax-xmin+1)*(ymax-ymin+1), with addresses in raster order.
  - Corners are held during FILL.
- Illegal state encoding 2'b00 goes to IDLE on the next clock.
- Arithmetic:
  - Compares on the corners are unsigned 10-bit.
  - Address sums are ADDR_W bits wide; the maximum is 307199, so there is no overflow.

Test Plan:
- Basic fill:
  - Stimulus: mark at (10,20), then mark at (12,21), wr_grant tied high.
  - Required: exactly 6 writes, one per cycle, at addresses 12810, 12811, 12812, 13450, 13451, 13452, with data = draw_color.
  - Required: done one cycle after the last write; state_rect sequence 10→01→11→10.
- Reversed corners:
  - Stimulus: pt1 at (12,21), pt2 at (10,20).
  - Required: the same 6 addresses in the same order as the basic fill.
- Grant stalls:
  - Stimulus: wr_grant toggles 1,0,0,1,… during a 2x2 fill at (0,0).
  - Required: addresses 0, 1, 640, 641, each held stable until granted; no write is duplicated or skipped.
- Rubber band and cancel:
  - Stimulus: mark at (5,5), then move the cursor to (100,50).
  - Required: recg_x_pt2 = 100 and recg_y_pt2 = 50 one cycle later.
  - Stimulus: btn_cancel.
  - Required: IDLE, no writes.
  - Stimulus: mark and cancel pulsed in the same cycle while in ANCHOR.
  - Required: IDLE.
- Clamp and single pixel:
  - Stimulus: cursor at (700,500) for both marks.
  - Required: a single write at address 307199; done pulses.
- Reset mid-fill:
  - Stimulus: assert reset_n low after the 3rd accept of a 4x4 fill.
  - Required: wr_req, busy and done go to 0 immediately and state_rect = 10.
  - Stimulus: a new mark after reset is released.
  - Required: the block starts cleanly in ANCHOR.
